jk_ubus_slave_mem: RTL and testbench

- Synthesizable UBUS slave responder with a local byte memory. Sits directly downstream of the UBUS bus interconnect, on the slave side.
- Replaces the pass-through bench DUT with a real responder:
  - decodes the address phase;
  - inserts wait states;
  - stores write bytes and returns read bytes;
  - signals error for out-of-window bursts.
- Used as the first real DUT for the jk UBUS VIP slave/master agents.

---
 rtl/jk_ubus_pkg.sv | 33 +++
 rtl/jk_ubus_slave_mem_if.sv | 29 ++
 rtl/jk_ubus_slave_mem_array.sv | 24 ++
 rtl/jk_ubus_slave_mem.sv | 171 +++++++++++++++++
 tb/tb_jk_ubus_slave_mem.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/jk_ubus_pkg.sv
// Shared types and constants for the jk UBUS slave memory responder.
package jk_ubus_pkg;

  typedef enum logic [1:0] {
    SIZE_1 = 2'b00,
    SIZE_2 = 2'b01,
    SIZE_4 = 2'b10,
    SIZE_8 = 2'b11
  } ubus_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } slave_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] size_to_bytes(input ubus_size_e s);
    logic [3:0] n;
    unique case (s)
      SIZE_1:  n = 4'd1;
      SIZE_2:  n = 4'd2;
      SIZE_4:  n = 4'd4;
      SIZE_8:  n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_ubus_slave_mem_if.sv
// UBUS slave-side signal bundle; the master modport drives the address/data phases.
interface jk_ubus_slave_mem_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);

  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              read;
  logic              write;
  logic              bip;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              wait_state;
  logic              error;
  logic              prot_err;

  modport master (
    output addr, size, read, write, bip, data_in,
    input  data_out, data_oe, wait_state, error, prot_err
  );

  modport slave (
    input  addr, size, read, write, bip, data_in,
    output data_out, data_oe, wait_state, error, prot_err
  );

endinterface

// File: rtl/jk_ubus_slave_mem_array.sv
// Single-port byte RAM: synchronous write, asynchronous read, no reset (macro-swappable).
module jk_ubus_slave_mem_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/jk_ubus_slave_mem.sv
// UBUS slave responder with local byte memory, wait-state insertion and window/protocol checks.
// Optional: define JK_UBUS_SLAVE_RAND_WAIT_EN for LFSR-driven random wait counts (0..3).
module jk_ubus_slave_mem
  import jk_ubus_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       DEPTH       = 256,
  parameter int unsigned       WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                reset,
  jk_ubus_slave_mem_if.slave  bus
);

  localparam int unsigned OFF_W = $clog2(DEPTH);

  slave_state_e      state;
  slave_state_e      state_nx;

  logic [OFF_W-1:0]  offset;
  logic [2:0]        beat;
  logic [2:0]        last_beat;
  logic [3:0]        wcnt;
  logic [3:0]        wait_len;
  logic              dir_rd;
  logic              oob;
  logic              prot_q;

  logic [ADDR_W:0]   rel;
  logic [ADDR_W:0]   span_end;
  logic [3:0]        nbytes;
  logic              hit;
  logic              accept;
  logic              clash;
  logic              stray;
  logic              bip_bad;
  logic              is_last;

  logic [OFF_W-1:0]  mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Address decode; a sub-BASE address wraps to a huge rel, so rel<DEPTH alone decides the hit
  always_comb begin
    rel      = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
    hit      = rel < (ADDR_W+1)'(DEPTH);
    nbytes   = size_to_bytes(ubus_size_e'(bus.size));
    span_end = rel + (ADDR_W+1)'(nbytes) - (ADDR_W+1)'(1);
    accept   = (bus.read ^ bus.write) && hit;
    is_last  = beat == last_beat;
    clash    = bus.read & bus.write;
    stray    = (state != IDLE) && (bus.read | bus.write);
    bip_bad  = (state == DATA) && (bus.bip != !is_last);
  end

`ifdef JK_UBUS_SLAVE_RAND_WAIT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign wait_len = {2'b00, lfsr[1:0]};
`else
  assign wait_len = 4'(WAIT_CYCLES);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (wait_len != '0) ? WAIT : DATA;
        end
      end
      WAIT: begin
        if (wcnt == '0) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        if (is_last) begin
          state_nx = IDLE;
        end else begin
          state_nx = (wait_len != '0) ? WAIT : DATA;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset    <= '0;
      beat      <= '0;
      last_beat <= '0;
      wcnt      <= '0;
      dir_rd    <= 1'b0;
      oob       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            offset    <= rel[OFF_W-1:0];
            last_beat <= 3'(nbytes - 4'd1);
            dir_rd    <= bus.read;
            oob       <= span_end >= (ADDR_W+1)'(DEPTH);
            beat      <= '0;
            wcnt      <= wait_len - 4'd1;
          end
        end
        WAIT: wcnt <= wcnt - 4'd1;
        DATA: begin
          if (!is_last) begin
            beat <= beat + 3'd1;
            wcnt <= wait_len - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prot_q <= 1'b0;
    end else if (((state == IDLE) && clash) || stray || bip_bad) begin
      prot_q <= 1'b1;
    end
  end

  always_comb begin
    mem_addr = offset + OFF_W'(beat);
    mem_we   = (state == DATA) && !dir_rd && !oob;
  end

  jk_ubus_slave_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (OFF_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (bus.data_in),
    .rdata (mem_rdata)
  );

  always_comb begin
    bus.wait_state = state == WAIT;
    bus.data_oe    = (state == DATA) && dir_rd;
    bus.error      = (state == DATA) && oob;
    bus.data_out   = ((state == DATA) && dir_rd && !oob) ? mem_rdata : '0;
    bus.prot_err   = prot_q;
  end

endmodule

// File: tb/tb_jk_ubus_slave_mem.sv
// Directed bench for jk_ubus_slave_mem: table of per-cycle vectors plus multi-cycle corner sequences.
module tb_jk_ubus_slave_mem;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  jk_ubus_slave_mem_if #(.ADDR_W(16), .DATA_W(8)) b0 ();
  jk_ubus_slave_mem_if #(.ADDR_W(16), .DATA_W(8)) b2 ();

  jk_ubus_slave_mem #(
    .ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'h0000), .DEPTH(256), .WAIT_CYCLES(0)
  ) u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );

  jk_ubus_slave_mem #(
    .ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'h0000), .DEPTH(256), .WAIT_CYCLES(2)
  ) u2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  size;
    logic        bip;
    logic [7:0]  din;
    logic        oe;
    logic        err;
    logic [7:0]  dout;
  } vec_t;

  vec_t tbl [80];
  int   n = 0;

  task automatic add(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] s,
                     input logic bip, input logic [7:0] din,
                     input logic oe, input logic err, input logic [7:0] dout);
    tbl[n] = '{rd, wr, a, s, bip, din, oe, err, dout};
    n++;
  endtask

  task automatic ap(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] s);
    add(rd, wr, a, s, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic bt(input logic bip, input logic [7:0] din, input logic oe, input logic err,
                    input logic [7:0] dout);
    add(1'b0, 1'b0, 16'h0000, 2'b00, bip, din, oe, err, dout);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] s,
                      input logic bip, input logic [7:0] din);
    b0.read = rd; b0.write = wr; b0.addr = a; b0.size = s; b0.bip = bip; b0.data_in = din;
  endtask

  task automatic drv2(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] s,
                      input logic bip, input logic [7:0] din);
    b2.read = rd; b2.write = wr; b2.addr = a; b2.size = s; b2.bip = bip; b2.data_in = din;
  endtask

  // One read beat on the zero-wait slave: check data, then advance
  task automatic rd_beat0(input string nm, input logic bip, input logic [7:0] exp);
    drv0(1'b0, 1'b0, 16'h0, 2'b00, bip, 8'h00);
    chk({nm, ".oe"}, 16'(b0.data_oe), 16'h1);
    chk({nm, ".dout"}, 16'(b0.data_out), 16'(exp));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ws_exp [6];
    bit oe_exp [6];
    logic [7:0] rd_exp [6];

    // zero-wait slave: write/read, window end, unselected addresses
    ap(0, 1, 16'h0010, 2);
    bt(1, 8'hA1, 0, 0, 8'h00); bt(1, 8'hB2, 0, 0, 8'h00);
    bt(1, 8'hC3, 0, 0, 8'h00); bt(0, 8'hD4, 0, 0, 8'h00);
    ap(1, 0, 16'h0010, 2);
    bt(1, 8'h00, 1, 0, 8'hA1); bt(1, 8'h00, 1, 0, 8'hB2);
    bt(1, 8'h00, 1, 0, 8'hC3); bt(0, 8'h00, 1, 0, 8'hD4);
    ap(0, 0, 16'h0000, 0);
    ap(0, 1, 16'h00FC, 2);
    bt(1, 8'h11, 0, 0, 8'h00); bt(1, 8'h22, 0, 0, 8'h00);
    bt(1, 8'h33, 0, 0, 8'h00); bt(0, 8'h44, 0, 0, 8'h00);
    ap(0, 1, 16'h00FC, 3);
    for (int i = 0; i < 8; i++) bt(i != 7, 8'hEE, 0, 1, 8'h00);
    ap(1, 0, 16'h00FC, 0); bt(0, 8'h00, 1, 0, 8'h11);
    ap(1, 0, 16'h00FF, 0); bt(0, 8'h00, 1, 0, 8'h44);
    ap(1, 0, 16'h00FF, 1); bt(1, 8'h00, 1, 1, 8'h00); bt(0, 8'h00, 1, 1, 8'h00);
    ap(1, 0, 16'h00FE, 1); bt(1, 8'h00, 1, 0, 8'h33); bt(0, 8'h00, 1, 0, 8'h44);
    ap(1, 0, 16'h0400, 0);
    for (int i = 0; i < 10; i++) ap(0, 0, 16'h0000, 0);
    ap(1, 0, 16'h0100, 0);
    for (int i = 0; i < 3; i++) ap(0, 0, 16'h0000, 0);

    ws_exp = '{1, 1, 0, 1, 1, 0};
    oe_exp = '{0, 0, 1, 0, 0, 1};
    rd_exp = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'hA5};

    reset = 1'b0;
    drv0(0, 0, 16'h0, 2'b00, 0, 8'h00);
    drv2(0, 0, 16'h0, 2'b00, 0, 8'h00);
    step();
    step();
    chk("rst.oe", 16'(b0.data_oe), 16'h0);
    chk("rst.ws", 16'(b2.wait_state), 16'h0);
    chk("rst.err", 16'(b0.error), 16'h0);
    chk("rst.dout", 16'(b0.data_out), 16'h0);
    chk("rst.perr", 16'(b0.prot_err), 16'h0);
    reset = 1'b1;
    step();

    for (int i = 0; i < n; i++) begin
      drv0(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].bip, tbl[i].din);
      chk($sformatf("v%0d.oe", i), 16'(b0.data_oe), 16'(tbl[i].oe));
      chk($sformatf("v%0d.err", i), 16'(b0.error), 16'(tbl[i].err));
      chk($sformatf("v%0d.dout", i), 16'(b0.data_out), 16'(tbl[i].dout));
      chk($sformatf("v%0d.ws", i), 16'(b0.wait_state), 16'h0);
      chk($sformatf("v%0d.perr", i), 16'(b0.prot_err), 16'h0);
      step();
    end
    drv0(0, 0, 16'h0, 2'b00, 0, 8'h00);

    // two-wait slave: write then read 0x20, two bytes
    drv2(0, 1, 16'h0020, 2'b01, 0, 8'h00);
    step();
    for (int k = 0; k < 6; k++) begin
      drv2(0, 0, 16'h0, 2'b00, k < 3, (k == 2) ? 8'h5A : (k == 5) ? 8'hA5 : 8'h00);
      chk($sformatf("w2wr%0d.ws", k), 16'(b2.wait_state), 16'(ws_exp[k]));
      step();
    end
    drv2(1, 0, 16'h0020, 2'b01, 0, 8'h00);
    chk("w2.idle_ws", 16'(b2.wait_state), 16'h0);
    step();
    for (int k = 0; k < 6; k++) begin
      drv2(0, 0, 16'h0, 2'b00, k < 3, 8'h00);
      chk($sformatf("w2rd%0d.ws", k), 16'(b2.wait_state), 16'(ws_exp[k]));
      chk($sformatf("w2rd%0d.oe", k), 16'(b2.data_oe), 16'(oe_exp[k]));
      chk($sformatf("w2rd%0d.dout", k), 16'(b2.data_out), 16'(rd_exp[k]));
      step();
    end
    chk("w2.done_ws", 16'(b2.wait_state), 16'h0);
    chk("w2.done_oe", 16'(b2.data_oe), 16'h0);
    chk("w2.perr", 16'(b2.prot_err), 16'h0);

    // read and write together: no transfer, sticky protocol error
    drv0(1, 1, 16'h0010, 2'b00, 0, 8'h00);
    step();
    drv0(0, 0, 16'h0, 2'b00, 0, 8'h00);
    chk("rw.perr", 16'(b0.prot_err), 16'h1);
    chk("rw.oe", 16'(b0.data_oe), 16'h0);
    chk("rw.err", 16'(b0.error), 16'h0);
    step();
    chk("rw.oe2", 16'(b0.data_oe), 16'h0);
    chk("rw.sticky", 16'(b0.prot_err), 16'h1);

    reset = 1'b0;
    #1;
    chk("rst2.perr_async", 16'(b0.prot_err), 16'h0);
    step();
    reset = 1'b1;
    step();

    // wrong bip on beat 0: flagged, burst length still follows size
    drv0(1, 0, 16'h0010, 2'b01, 0, 8'h00);
    step();
    rd_beat0("bip.b0", 1'b0, 8'hA1);
    chk("bip.perr", 16'(b0.prot_err), 16'h1);
    rd_beat0("bip.b1", 1'b0, 8'hB2);
    chk("bip.end_oe", 16'(b0.data_oe), 16'h0);

    // preload 0x40..0x43, then abort a rewrite during beat 2
    drv0(0, 1, 16'h0040, 2'b10, 0, 8'h00);
    step();
    for (int k = 0; k < 4; k++) begin
      drv0(0, 0, 16'h0, 2'b00, k < 3, 8'hF0 + 8'(k));
      step();
    end
    drv0(0, 1, 16'h0040, 2'b10, 0, 8'h00);
    step();
    drv0(0, 0, 16'h0, 2'b00, 1, 8'h01);
    step();
    drv0(0, 0, 16'h0, 2'b00, 1, 8'h02);
    step();
    drv0(0, 0, 16'h0, 2'b00, 1, 8'h03);
    #2;
    reset = 1'b0;
    #1;
    chk("mid.perr_async", 16'(b0.prot_err), 16'h0);
    chk("mid.oe", 16'(b0.data_oe), 16'h0);
    chk("mid.err", 16'(b0.error), 16'h0);
    drv0(0, 0, 16'h0, 2'b00, 0, 8'h00);
    step();
    reset = 1'b1;
    drv0(1, 0, 16'h0040, 2'b00, 0, 8'h00);
    step();
    rd_beat0("mid.r1", 1'b0, 8'h01);
    drv0(1, 0, 16'h0040, 2'b10, 0, 8'h00);
    step();
    rd_beat0("mid.m0", 1'b1, 8'h01);
    rd_beat0("mid.m1", 1'b1, 8'h02);
    rd_beat0("mid.m2", 1'b1, 8'hF2);
    rd_beat0("mid.m3", 1'b0, 8'hF3);
    chk("mid.perr_end", 16'(b0.prot_err), 16'h0);
    chk("mid.idle_oe", 16'(b0.data_oe), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
